imem_loader: RTL and testbench



---
 rtl/imem_loader_pkg.sv | 21 ++
 rtl/byte_assembler.sv | 42 ++++
 rtl/imem_loader.sv | 105 ++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: shared types and constants for the instruction-memory boot loader.
//   state_t        - loader FSM states
//   BYTES_PER_WORD - payload bytes per instruction word on the stream
//   HDR_BYTES      - word-count header length in bytes
package imem_loader_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    HDR_HI = 3'd1,
    HDR_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CSUM   = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int HDR_BYTES      = 2;

endpackage

// File: rtl/byte_assembler.sv
// byte_assembler: packs big-endian stream bytes into a 32-bit word.
//   clk, rst   - clock, async active-high reset
//   shift      - accept data into the low byte, shifting older bytes up
//   clear      - empty the assembler (word has been consumed)
//   data       - incoming byte
//   word       - low OUT_W bits of the assembled word
//   word_full  - pulses with the shift that completes a word
module byte_assembler
  import imem_loader_pkg::*;
#(
  parameter int OUT_W = 26
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             shift,
  input  logic             clear,
  input  logic [7:0]       data,
  output logic [OUT_W-1:0] word,
  output logic             word_full
);

  logic [31:0] sr;
  logic [1:0]  cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr  <= '0;
      cnt <= '0;
    end else if (clear) begin
      sr  <= '0;
      cnt <= '0;
    end else if (shift) begin
      // Oldest byte falls off the top; the truncating cast keeps the low 32 bits.
      sr  <= 32'({sr, data});
      cnt <= cnt + 2'd1;
    end
  end

  assign word_full = shift && (cnt == 2'(BYTES_PER_WORD - 1));
  assign word      = sr[OUT_W-1:0];

endmodule

// File: rtl/imem_loader.sv
// imem_loader: framed byte-stream boot loader for instruction memory.
// Frame: N (2 bytes, big-endian), N x 4 payload bytes (big-endian, bits
// [31:26] dropped), then a checksum byte equal to the mod-256 sum of all
// preceding frame bytes. CPU_Start rises only after a matching checksum.
//   CLK, RST            - clock, async active-high reset
//   BYTE_In/Valid/Ready - input byte stream handshake
//   IM_WE/Addr/WData    - instruction memory write port (one strobe per word)
//   CPU_Start           - releases the CPU after a verified load
//   Load_Err            - sticky error: oversize image or bad checksum
//   Word_Count          - words written so far
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int          ADDR_W    = 16,
  parameter int          INSTR_W   = 26,
  parameter int unsigned MAX_WORDS = 256
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic [7:0]         BYTE_In,
  input  logic               BYTE_Valid,
  output logic               BYTE_Ready,
  output logic               IM_WE,
  output logic [ADDR_W-1:0]  IM_Addr,
  output logic [INSTR_W-1:0] IM_WData,
  output logic               CPU_Start,
  output logic               Load_Err,
  output logic [ADDR_W-1:0]  Word_Count
);

  state_t              state, next;
  logic [7:0]          hdr_hi;
  logic [15:0]         n_words;
  logic [7:0]          sum;
  logic [ADDR_W-1:0]   idx;
  logic [ADDR_W-1:0]   idx_inc;
  logic [15:0]         n_hdr;
  logic                ready;
  logic                accept;
  logic                last_word;
  logic                word_full;
  logic [INSTR_W-1:0]  word;

  assign ready     = (state == HDR_HI) || (state == HDR_LO) ||
                     (state == DATA)   || (state == CSUM);
  assign accept    = BYTE_Valid && ready;
  assign n_hdr     = {hdr_hi, BYTE_In};
  assign idx_inc   = idx + ADDR_W'(1);
  assign last_word = (32'(idx_inc) == 32'(n_words));

  byte_assembler #(.OUT_W(INSTR_W)) u_asm (
    .clk       (CLK),
    .rst       (RST),
    .shift     (accept && (state == DATA)),
    .clear     (state == WRITE),
    .data      (BYTE_In),
    .word      (word),
    .word_full (word_full)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE:   next = HDR_HI;
      HDR_HI: if (accept) next = HDR_LO;
      HDR_LO: if (accept) begin
        if (32'(n_hdr) > MAX_WORDS) next = ERR;
        else if (n_hdr == 16'd0)     next = CSUM;
        else                         next = DATA;
      end
      DATA:   if (word_full) next = WRITE;
      WRITE:  next = last_word ? CSUM : DATA;
      CSUM:   if (accept) next = (BYTE_In == sum) ? DONE : ERR;
      DONE:   next = DONE;
      ERR:    next = ERR;
      default: next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      hdr_hi  <= '0;
      n_words <= '0;
      sum     <= '0;
      idx     <= '0;
    end else begin
      state <= next;
      if (accept && (state == HDR_HI)) hdr_hi  <= BYTE_In;
      if (accept && (state == HDR_LO)) n_words <= n_hdr;
      // Checksum byte itself is not summed; everything before it is.
      if (accept && (state != CSUM))   sum     <= sum + BYTE_In;
      if (state == WRITE)              idx     <= idx_inc;
    end
  end

  assign BYTE_Ready = ready;
  assign IM_WE      = (state == WRITE);
  assign IM_Addr    = IM_WE ? idx  : '0;
  assign IM_WData   = IM_WE ? word : '0;
  assign CPU_Start  = (state == DONE);
  assign Load_Err   = (state == ERR);
  assign Word_Count = idx;

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;
  localparam int ADDR_W  = 16;
  localparam int INSTR_W = 26;

  logic               CLK = 1'b0;
  logic               RST = 1'b0;
  logic [7:0]         BYTE_In = 8'h00;
  logic               BYTE_Valid = 1'b0;
  logic               BYTE_Ready;
  logic               IM_WE;
  logic [ADDR_W-1:0]  IM_Addr;
  logic [INSTR_W-1:0] IM_WData;
  logic               CPU_Start;
  logic               Load_Err;
  logic [ADDR_W-1:0]  Word_Count;

  imem_loader #(.ADDR_W(ADDR_W), .INSTR_W(INSTR_W), .MAX_WORDS(256)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .BYTE_In    (BYTE_In),
    .BYTE_Valid (BYTE_Valid),
    .BYTE_Ready (BYTE_Ready),
    .IM_WE      (IM_WE),
    .IM_Addr    (IM_Addr),
    .IM_WData   (IM_WData),
    .CPU_Start  (CPU_Start),
    .Load_Err   (Load_Err),
    .Word_Count (Word_Count)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;

  // Write log: every IM strobe seen mid-cycle.
  logic [ADDR_W-1:0]  log_addr [0:63];
  logic [INSTR_W-1:0] log_data [0:63];
  time                log_t    [0:63];
  int                 wr_n = 0;
  int                 base;
  logic [7:0]         img[$];

  always @(negedge CLK) begin
    if (IM_WE) begin
      if (wr_n < 64) begin
        log_addr[wr_n] = IM_Addr;
        log_data[wr_n] = IM_WData;
        log_t[wr_n]    = $time;
      end
      wr_n++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Offer one byte after 'gap' idle cycles and hold it until accepted.
  // Returns just after the accepting rising edge.
  task automatic send(input logic [7:0] b, input int gap);
    int t;
    t = 0;
    repeat (gap) begin
      @(negedge CLK);
      BYTE_Valid = 1'b0;
      BYTE_In    = 8'($urandom);
    end
    @(negedge CLK);
    BYTE_Valid = 1'b1;
    BYTE_In    = b;
    while (!BYTE_Ready && t < 40) begin
      @(negedge CLK);
      t++;
    end
    if (!BYTE_Ready) chk("send_timeout", 32'(BYTE_Ready), 32'd1);
    @(posedge CLK);
  endtask

  task automatic send_seq(input int maxgap);
    foreach (img[i]) send(img[i], int'($urandom_range(32'(maxgap), 0)));
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(negedge CLK);
      BYTE_Valid = 1'b0;
    end
  endtask

  task automatic release_reset();
    @(negedge CLK);
    RST = 1'b0;
    #1 chk("ready_after_rst", 32'(BYTE_Ready), 32'd0);
    @(posedge CLK);
    #1 chk("ready_rise", 32'(BYTE_Ready), 32'd1);
  endtask

  task automatic do_reset();
    BYTE_Valid = 1'b0;
    RST = 1'b1;
    #2;
    release_reset();
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset values ----
    BYTE_Valid = 1'b0;
    RST = 1'b1;
    #2;
    chk("rst_ready", 32'(BYTE_Ready), 32'd0);
    chk("rst_we",    32'(IM_WE),      32'd0);
    chk("rst_addr",  32'(IM_Addr),    32'd0);
    chk("rst_wdata", 32'(IM_WData),   32'd0);
    chk("rst_start", 32'(CPU_Start),  32'd0);
    chk("rst_err",   32'(Load_Err),   32'd0);
    chk("rst_wcnt",  32'(Word_Count), 32'd0);
    release_reset();

    // ---- good image, full rate ----
    base = wr_n;
    send(8'h00, 0); send(8'h02, 0);
    send(8'h01, 0); send(8'h23, 0); send(8'h45, 0); send(8'h67, 0);
    #1;
    chk("w0_we",    32'(IM_WE),      32'd1);
    chk("w0_addr",  32'(IM_Addr),    32'd0);
    chk("w0_data",  32'(IM_WData),   32'h1234567);
    chk("w0_ready", 32'(BYTE_Ready), 32'd0);
    chk("w0_wcnt",  32'(Word_Count), 32'd0);
    send(8'h00, 0); send(8'h00, 0); send(8'h00, 0); send(8'h2A, 0);
    #1;
    chk("w1_we",   32'(IM_WE),      32'd1);
    chk("w1_addr", 32'(IM_Addr),    32'd1);
    chk("w1_data", 32'(IM_WData),   32'h000002A);
    chk("w1_wcnt", 32'(Word_Count), 32'd1);
    send(8'hFC, 0);
    #1;
    chk("good_start", 32'(CPU_Start),  32'd1);
    chk("good_err",   32'(Load_Err),   32'd0);
    chk("good_wcnt",  32'(Word_Count), 32'd2);
    chk("good_ready", 32'(BYTE_Ready), 32'd0);
    idle(3);
    chk("good_nwr",   32'(wr_n - base), 32'd2);
    chk("good_rate",  32'(log_t[base+1] - log_t[base]), 32'd50);
    chk("good_hold",  32'(CPU_Start), 32'd1);

    // ---- bad checksum ----
    do_reset();
    base = wr_n;
    img = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'h00, 8'h00, 8'h2A, 8'hFD};
    send_seq(0);
    #1;
    chk("bad_err",   32'(Load_Err),   32'd1);
    chk("bad_start", 32'(CPU_Start),  32'd0);
    chk("bad_ready", 32'(BYTE_Ready), 32'd0);
    idle(2);
    chk("bad_nwr",   32'(wr_n - base), 32'd2);

    // ---- oversize header ----
    do_reset();
    base = wr_n;
    send(8'h01, 0); send(8'h01, 0);
    #1;
    chk("big_err",   32'(Load_Err),   32'd1);
    chk("big_ready", 32'(BYTE_Ready), 32'd0);
    @(negedge CLK);
    BYTE_Valid = 1'b1;
    BYTE_In    = 8'h55;
    repeat (6) @(posedge CLK);
    idle(1);
    chk("big_nwr",   32'(wr_n - base), 32'd0);
    chk("big_start", 32'(CPU_Start),   32'd0);
    chk("big_stick", 32'(Load_Err),    32'd1);

    // ---- empty image ----
    do_reset();
    base = wr_n;
    img = '{8'h00, 8'h00, 8'h00};
    send_seq(0);
    #1;
    chk("empty_start", 32'(CPU_Start),  32'd1);
    chk("empty_wcnt",  32'(Word_Count), 32'd0);
    idle(2);
    chk("empty_nwr",   32'(wr_n - base), 32'd0);

    // ---- throttled stream ----
    do_reset();
    base = wr_n;
    img = '{8'h00, 8'h02, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h12, 8'h34, 8'h56, 8'h78, 8'h12};
    send_seq(3);
    #1;
    chk("thr_start", 32'(CPU_Start), 32'd1);
    chk("thr_err",   32'(Load_Err),  32'd0);
    idle(2);
    chk("thr_nwr",   32'(wr_n - base), 32'd2);
    chk("thr_a0",    32'(log_addr[base]),   32'd0);
    chk("thr_d0",    32'(log_data[base]),   32'h3FFFFFF);
    chk("thr_a1",    32'(log_addr[base+1]), 32'd1);
    chk("thr_d1",    32'(log_data[base+1]), 32'h2345678);
    chk("thr_wcnt",  32'(Word_Count), 32'd2);

    // ---- reset mid-word, then reload ----
    do_reset();
    img = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'h00};
    send_seq(0);
    #1 chk("mid_pre_wcnt", 32'(Word_Count), 32'd1);
    #1 RST = 1'b1;
    BYTE_Valid = 1'b0;
    #1;
    chk("mid_wcnt",  32'(Word_Count), 32'd0);
    chk("mid_ready", 32'(BYTE_Ready), 32'd0);
    chk("mid_we",    32'(IM_WE),      32'd0);
    chk("mid_start", 32'(CPU_Start),  32'd0);
    chk("mid_err",   32'(Load_Err),   32'd0);
    release_reset();
    base = wr_n;
    img = '{8'h00, 8'h02, 8'h01, 8'h23, 8'h45, 8'h67, 8'h00, 8'h00, 8'h00, 8'h2A, 8'hFC};
    send_seq(0);
    #1 chk("rl_start", 32'(CPU_Start), 32'd1);
    idle(2);
    chk("rl_nwr", 32'(wr_n - base), 32'd2);
    chk("rl_a0",  32'(log_addr[base]),   32'd0);
    chk("rl_d0",  32'(log_data[base]),   32'h1234567);
    chk("rl_a1",  32'(log_addr[base+1]), 32'd1);
    chk("rl_d1",  32'(log_data[base+1]), 32'h000002A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
